// File: rtl/seq_monitor_7seg.sv
// Sequence monitor for a 2-bit 0->1->2->3 state code.
// Tracks lock, faults and wraps, and shows the even value on a 7-segment digit.
module seq_monitor_7seg #(
  parameter int LOCK_N         = 4,
  parameter int WRAP_W         = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [1:0]        seq_in,
  output logic              locked,
  output logic              fault,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [2:0]        value,
  output logic [6:0]        seg
);

  localparam int CW = $clog2(LOCK_N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACQ   = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [6:0] BLANK =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [CW-1:0] LOCK_CNT = CW'(LOCK_N);

  logic [1:0]    state;
  logic [1:0]    prev;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] cnt_inc;
  logic          good;
  logic          is_wrap;

  // Segment pattern for the even value 2*c, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] enc(input logic [1:0] c);
    logic [6:0] p;
    unique case (c)
      2'd0: p = 7'h40;
      2'd1: p = 7'h24;
      2'd2: p = 7'h19;
      2'd3: p = 7'h02;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  assign good    = (seq_in == prev + 2'd1);
  assign cnt_inc = good_cnt + CW'(1);
  assign is_wrap = (prev == 2'd3) && (seq_in == 2'd0);

  assign locked = (state == S_LOCK);
  assign fault  = (state == S_FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      prev       <= 2'd0;
      good_cnt   <= '0;
      err_sticky <= 1'b0;
      wrap_cnt   <= '0;
      value      <= 3'd0;
      seg        <= BLANK;
    end else if (clr) begin
      state      <= S_IDLE;
      prev       <= 2'd0;
      good_cnt   <= '0;
      err_sticky <= 1'b0;
      wrap_cnt   <= '0;
      value      <= 3'd0;
      seg        <= BLANK;
    end else if (en) begin
      prev  <= seq_in;
      value <= {seq_in, 1'b0};
      seg   <= enc(seq_in);
      unique case (state)
        S_IDLE: begin
          good_cnt <= '0;
          state    <= S_ACQ;
        end
        S_ACQ: begin
          if (good) begin
            good_cnt <= cnt_inc;
            if (cnt_inc == LOCK_CNT)
              state <= S_LOCK;
          end else begin
            good_cnt <= '0;
          end
        end
        S_LOCK: begin
          if (good) begin
            // Counter saturates so a long run never reads as few wraps.
            if (is_wrap && (wrap_cnt != '1))
              wrap_cnt <= wrap_cnt + WRAP_W'(1);
          end else begin
            state      <= S_FAULT;
            err_sticky <= 1'b1;
          end
        end
        S_FAULT: begin
          good_cnt <= '0;
          state    <= S_ACQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_monitor_7seg.sv
// Bench for seq_monitor_7seg: reference model checked every cycle
// on two parameterisations, plus directed literal checks.
module tb_seq_monitor_7seg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] seq_in = 2'd0;

  logic       lk_a, ft_a, st_a;
  logic [7:0] wr_a;
  logic [2:0] vl_a;
  logic [6:0] sg_a;
  logic       lk_b, ft_b, st_b;
  logic [1:0] wr_b;
  logic [2:0] vl_b;
  logic [6:0] sg_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_monitor_7seg dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .seq_in(seq_in),
    .locked(lk_a), .fault(ft_a), .err_sticky(st_a),
    .wrap_cnt(wr_a), .value(vl_a), .seg(sg_a)
  );

  seq_monitor_7seg #(
    .LOCK_N(1), .WRAP_W(2), .SEG_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .seq_in(seq_in),
    .locked(lk_b), .fault(ft_b), .err_sticky(st_b),
    .wrap_cnt(wr_b), .value(vl_b), .seg(sg_b)
  );

  // Model: 0 idle, 1 acquiring, 2 locked, 3 faulted
  int ph[2], run[2], last[2], wraps[2];
  int stk[2], val[2], have[2];
  int lockn[2] = '{4, 1};
  int wmax[2]  = '{255, 3};
  int actlo[2] = '{1, 0};
  int pat[4]   = '{'h40, 'h24, 'h19, 'h02};

  task automatic mreset(int i);
    ph[i] = 0; run[i] = 0; last[i] = 0; wraps[i] = 0;
    stk[i] = 0; val[i] = 0; have[i] = 0;
  endtask

  task automatic mstep(int i, int s);
    bit ok;
    ok = (s == (last[i] + 1) % 4);
    case (ph[i])
      0: begin run[i] = 0; ph[i] = 1; end
      1: if (ok) begin
           run[i]++;
           if (run[i] == lockn[i]) ph[i] = 2;
         end else run[i] = 0;
      2: if (ok) begin
           if (last[i] == 3 && s == 0 && wraps[i] < wmax[i])
             wraps[i]++;
         end else begin
           ph[i] = 3; stk[i] = 1;
         end
      default: begin run[i] = 0; ph[i] = 1; end
    endcase
    last[i] = s; val[i] = 2 * s; have[i] = 1;
  endtask

  function automatic int segexp(int i);
    int p;
    p = have[i] ? pat[val[i] / 2] : 'h7F;
    return actlo[i] ? p : (~p & 'h7F);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || clr) mreset(i);
      else if (en) mstep(i, int'(seq_in));
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_locked", int'(lk_a), int'(ph[0] == 2));
    chk("a_fault",  int'(ft_a), int'(ph[0] == 3));
    chk("a_sticky", int'(st_a), stk[0]);
    chk("a_wrap",   int'(wr_a), wraps[0]);
    chk("a_value",  int'(vl_a), val[0]);
    chk("a_seg",    int'(sg_a), segexp(0));
    chk("b_locked", int'(lk_b), int'(ph[1] == 2));
    chk("b_fault",  int'(ft_b), int'(ph[1] == 3));
    chk("b_sticky", int'(st_b), stk[1]);
    chk("b_wrap",   int'(wr_b), wraps[1]);
    chk("b_value",  int'(vl_b), val[1]);
    chk("b_seg",    int'(sg_b), segexp(1));
  end

  task automatic drive(bit e, bit c, logic [1:0] s);
    en = e; clr = c; seq_in = s;
    @(posedge clk); #1;
  endtask

  initial begin
    int t2seg[5] = '{'h40, 'h24, 'h19, 'h02, 'h40};
    logic [1:0] t2in[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    chk("t1_locked", int'(lk_a), 0);
    chk("t1_sticky", int'(st_a), 0);
    chk("t1_wrap",   int'(wr_a), 0);
    chk("t1_seg_a",  int'(sg_a), 'h7F);
    chk("t1_seg_b",  int'(sg_b), 'h00);
    rst = 1'b0;
    repeat (3) drive(0, 0, 2'd2);
    chk("t1_hold_seg", int'(sg_a), 'h7F);
    chk("t1_hold_val", int'(vl_a), 0);

    // T2 lock
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, t2in[k]);
      chk("t2_seg", int'(sg_a), t2seg[k]);
      chk("t2_locked", int'(lk_a), int'(k == 4));
    end
    chk("t2_b_locked", int'(lk_b), 1);
    chk("t2_b_seg", int'(sg_b), 'h3F);

    // T3 wraps, with saturation on the narrow counter
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 2'd1);
      drive(1, 0, 2'd2);
      drive(1, 0, 2'd3);
      drive(1, 0, 2'd0);
      if (c == 2) chk("t3_wrap3", int'(wr_a), 3);
    end
    chk("t3_wrap5", int'(wr_a), 5);
    chk("t3_sat_b", int'(wr_b), 3);

    // T4 fault: 0 -> 2
    drive(1, 0, 2'd2);
    chk("t4_fault",  int'(ft_a), 1);
    chk("t4_unlock", int'(lk_a), 0);
    chk("t4_sticky", int'(st_a), 1);
    chk("t4_b_fault", int'(ft_b), 1);
    drive(1, 0, 2'd3);
    chk("t4_fault_gone", int'(ft_a), 0);
    chk("t4_acq", int'(lk_a), 0);
    drive(1, 0, 2'd0);
    drive(1, 0, 2'd1);
    drive(1, 0, 2'd2);
    chk("t4_not_yet", int'(lk_a), 0);
    drive(1, 0, 2'd3);
    chk("t4_relock", int'(lk_a), 1);
    chk("t4_sticky_held", int'(st_a), 1);
    chk("t4_wrap_kept", int'(wr_a), 5);

    // T5 gating
    for (int k = 0; k < 10; k++)
      drive(0, 0, 2'($urandom_range(0, 3)));
    chk("t5_wrap", int'(wr_a), 5);
    chk("t5_seg",  int'(sg_a), 'h02);
    chk("t5_lock", int'(lk_a), 1);

    // T6 clr beats en, then async reset mid-lock
    drive(1, 1, 2'd0);
    chk("t6_clr_lock", int'(lk_a), 0);
    chk("t6_clr_wrap", int'(wr_a), 0);
    chk("t6_clr_stk",  int'(st_a), 0);
    chk("t6_clr_seg",  int'(sg_a), 'h7F);
    for (int k = 0; k < 5; k++) drive(1, 0, t2in[k]);
    drive(1, 0, 2'd1);
    chk("t6_relock", int'(lk_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_lock", int'(lk_a), 0);
    chk("t6_rst_seg",  int'(sg_a), 'h7F);
    chk("t6_rst_val",  int'(vl_a), 0);
    chk("t6_rst_b_seg", int'(sg_b), 'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 0, 2'd2);
    chk("t6_resume_val", int'(vl_a), 4);
    chk("t6_resume_seg", int'(sg_a), 'h19);
    drive(1, 0, 2'd3);
    drive(0, 0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
